// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port word memory (async read, sync write) between an
//   instruction-fetch requester (I, read-only) and a load/store requester
//   (D, read/write). D has priority; a starvation counter forces an I grant
//   after STARVE_LIMIT consecutive D grants while I is waiting.
//   Each access walks IDLE -> ACCESS -> RESP, so one access per 3 cycles max.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_req/i_addr          I request (held until i_ack) and byte address
//   i_ack/i_rdata         I completion pulse and read data
//   d_req/d_we/d_addr/    D request (held until d_ack), write enable,
//   d_wdata                 byte address, write data
//   d_ack/d_rdata/d_err   D completion pulse, read data, misalignment error
//   mem_addr/mem_din      memory byte address and write data
//   mem_read/mem_write    memory read / write enables
//   mem_dout              memory read data, combinational from mem_addr
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = D owns the access, 0 = I
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              misal_q, misal_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic force_i;
  logic grant_d;
  logic grant_i;
  logic d_misal;

  // Grant decision: D wins unless I has waited out the starvation limit.
  always_comb begin
    force_i = i_req && (starve_q == CNT_W'(STARVE_LIMIT));
    grant_d = d_req && !force_i;
    grant_i = i_req && !grant_d;
    d_misal = |d_addr[1:0];
  end

  // State register and all output/holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      misal_q     <= 1'b0;
      starve_q    <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      misal_q     <= misal_d;
      starve_q    <= starve_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    misal_d     = misal_q;
    starve_d    = starve_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Starvation count only tracks D grants that overtake a waiting I.
        if (!i_req) begin
          starve_d = '0;
        end else if (grant_d) begin
          if (starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else begin
          starve_d = '0;
        end

        if (grant_d) begin
          owner_d_d   = 1'b1;
          addr_d      = d_addr;
          we_d        = d_we;
          wdata_d     = d_wdata;
          misal_d     = d_misal;
          mem_read_d  = !d_we && !d_misal;
          mem_write_d = d_we && !d_misal;
          state_d     = ACCESS;
        end else if (grant_i) begin
          owner_d_d   = 1'b0;
          addr_d      = i_addr;
          we_d        = 1'b0;
          misal_d     = 1'b0;
          mem_read_d  = 1'b1;
          state_d     = ACCESS;
        end
      end

      ACCESS: begin
        // Memory is addressed this cycle; capture read data at the closing edge.
        state_d = RESP;
        if (owner_d_q) begin
          d_ack_d = 1'b1;
          d_err_d = misal_q;
          if (!we_q && !misal_q) begin
            d_rdata_d = mem_dout;
          end
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = mem_dout;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_ack    = i_ack_q;
  assign i_rdata  = i_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_err    = d_err_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign mem_read = mem_read_q;
  // A reset arriving mid-ACCESS must not let the pending write commit.
  assign mem_write = mem_write_q && !reset;

endmodule
